hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Reader-side counterpart of the stage pipeline registers' Tnew countdown. It keeps its own shadow copy of the E, M and W stage contents: dest reg, Tnew, rs and rt.
- Each cycle it compares the D-stage operands and their Tuse against that shadow.
- From the comparison it drives the pipeline stall and all forwarding-mux selects for the 5-stage MIPS core.
- Sits beside the D/E, E/M and M/W registers and advances in lockstep with them.

Parameters:
- TNEW_W, 5, width of Tnew fields (matches stage registers).
- TUSE_W, 2, width of Tuse fields (values 0..2).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clears all shadow stages.
- en  in  1  global pipeline enable; 0 freezes all shadow stages.
- d_rs  in  5  rs of the instruction in D.
- d_rt  in  5  rt of the instruction in D.
- d_tuse_rs  in  TUSE_W  cycles until the D instruction consumes rs; D-relative, 0 = used in D.
- d_tuse_rt  in  TUSE_W  same for rt.
- d_a3  in  5  destination reg of the D instruction; 0 = no write.
- d_tnew  in  TNEW_W  Tnew the D instruction will carry on entering E.
- d_valid  in  1  D holds a real instruction; 0 = bubble.
- stall  out  1  hold PC and F/D, insert bubble into D/E.
- fwd_d_rs  out  2  D-operand select: 0 RF, 1 from E, 2 from M, 3 from W.
- fwd_d_rt  out  2  same for rt.
- fwd_e_rs  out  2  E-operand select: 0 D/E reg, 2 from M, 3 from W.
- fwd_e_rt  out  2  same for rt.
- fwd_m_rt  out  2  M store-data select: 0 E/M reg, 3 from W.

Behaviour:
- State: three shadow entries E, M, W. Each holds {a3[4:0], tnew[TNEW_W-1:0], rs[4:0], rt[4:0]}.
- Reset, and the power-on initial value: all entries zero.
  - With all-zero state, stall=0 and every fwd_*=0 for any D inputs.
- Reset asserted mid-operation: clears the shadow on that edge, overriding en. Outputs are 0 from the following cycle.
- Posedge with en=1 and reset=0:
  - W <= M with tnew' = (M.tnew>0) ? M.tnew-1 : 0.
  - M <= E with the same saturating decrement.
  - E <= {d_a3, d_tnew, d_rs, d_rt} if d_valid=1 and stall=0; otherwise E <= all-zero bubble.
- en=0: all entries hold. Outputs continue to be evaluated combinationally from the held state.
- Match rule: stage X matches src when src != 0 and X.a3 == src. Reg $0 never matches, never stalls, never forwards.
- Stall rule:
  - stall = d_valid AND any(X in E, M, W matches a D source with X.tnew > that source's Tuse), evaluated for rs and rt independently.
  - Purely combinational, zero latency.
  - A stall repeats each cycle until the producer's Tnew has decremented enough. Each stall cycle inserts exactly one bubble.
- Forward rule (every consumer): pick the nearest matching stage, priority E > M > W for D; M > W for E; W for M.
  - If that nearest matching stage has tnew == 0, drive its code.
  - Otherwise drive 0. An older stage is never selected past a younger matching writer, since that value is stale.
  - fwd_e_* compare E.rs/E.rt against M and W; fwd_m_rt compares M.rt against W.
- Simultaneous match of rs and rt to different stages: the selects are independent.
- rs == rt: both selects are identical.
- Tnew saturates at 0 and never wraps. Tuse is compared unsigned against the full Tnew width.
- A D-stage forward from W is required, since the RF is not write-through.

Test Plan:
- Load-use: lw $8 (d_tnew=2) then add rs=$8, tuse=1.
  - Cycle after lw issues: stall=1 for exactly one cycle, E becomes a bubble.
  - Next cycle: stall=0, add enters E; the cycle after, fwd_e_rs=3.
- ALU-to-branch: add $9 (d_tnew=1) then beq rs=$9, tuse=0.
  - One stall cycle, then fwd_d_rs=2 with add in M, tnew=0.
- jal/jr: jal (d_a3=31, d_tnew=0) then jr rs=$31, tuse=0.
  - stall=0, fwd_d_rs=1 immediately.
- Store data: lw $10 (d_tnew=2) then sw rt=$10, tuse_rt=2.
  - No stall; fwd_e_rt=0 while lw in M has tnew=1.
  - Next cycle fwd_m_rt=3.
- $0 and priority:
  - Writer with d_a3=0, d_tnew=2, then reader of $0 -> stall=0, all selects 0.
  - Two adds both writing $5 back-to-back, then a reader of $5 in E -> fwd_e_rs=2 (M), not 3.
- en/reset:
  - en=0 during an active load-use stall -> stall stays 1 and state holds.
  - reset pulse -> next cycle stall=0 and all selects 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage MIPS core: shadows the E/M/W dest/Tnew/rs/rt
// and derives the D-stage stall plus every forwarding-mux select from that shadow.
module hazard_scoreboard #(
    parameter int unsigned TNEW_W = 5,
    parameter int unsigned TUSE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic [TUSE_W-1:0] d_tuse_rs,
    input  logic [TUSE_W-1:0] d_tuse_rt,
    input  logic [4:0]        d_a3,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_valid,
    output logic              stall,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic [1:0]        fwd_m_rt
);

    typedef struct packed {
        logic [4:0]        a3;
        logic [TNEW_W-1:0] tnew;
        logic [4:0]        rs;
        logic [4:0]        rt;
    } stage_t;

    stage_t e_stage, m_stage, w_stage;

    function automatic logic hit(input logic [4:0] a3, input logic [4:0] src);
        return (src != 5'd0) && (a3 == src);
    endfunction

    function automatic stage_t age(input stage_t s);
        stage_t r;
        r = s;
        if (s.tnew != '0)
            r.tnew = s.tnew - TNEW_W'(1);
        return r;
    endfunction

    // A producer is too late when its remaining Tnew exceeds the consumer's Tuse.
    function automatic logic late(input logic [4:0] src, input logic [TUSE_W-1:0] tuse,
                                  input stage_t e, input stage_t m, input stage_t w);
        logic [TNEW_W-1:0] t;
        t = TNEW_W'(tuse);
        return (hit(e.a3, src) && (e.tnew > t)) ||
               (hit(m.a3, src) && (m.tnew > t)) ||
               (hit(w.a3, src) && (w.tnew > t));
    endfunction

    // Nearest matching writer wins; if it is not ready yet, fall back to the
    // pipeline register rather than an older (stale) writer.
    function automatic logic [1:0] pick(input logic [4:0] src, input logic use_e,
                                        input stage_t e, input stage_t m, input stage_t w);
        if (use_e && hit(e.a3, src))
            return (e.tnew == '0) ? 2'd1 : 2'd0;
        else if (hit(m.a3, src))
            return (m.tnew == '0) ? 2'd2 : 2'd0;
        else if (hit(w.a3, src))
            return (w.tnew == '0) ? 2'd3 : 2'd0;
        else
            return 2'd0;
    endfunction

    always_comb begin
        stall    = d_valid && (late(d_rs, d_tuse_rs, e_stage, m_stage, w_stage) ||
                               late(d_rt, d_tuse_rt, e_stage, m_stage, w_stage));
        fwd_d_rs = pick(d_rs, 1'b1, e_stage, m_stage, w_stage);
        fwd_d_rt = pick(d_rt, 1'b1, e_stage, m_stage, w_stage);
        fwd_e_rs = pick(e_stage.rs, 1'b0, e_stage, m_stage, w_stage);
        fwd_e_rt = pick(e_stage.rt, 1'b0, e_stage, m_stage, w_stage);
        fwd_m_rt = (hit(w_stage.a3, m_stage.rt) && (w_stage.tnew == '0)) ? 2'd3 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_stage <= '0;
            m_stage <= '0;
            w_stage <= '0;
        end else if (en) begin
            w_stage <= age(m_stage);
            m_stage <= age(e_stage);
            if (d_valid && !stall)
                e_stage <= {d_a3, d_tnew, d_rs, d_rt};
            else
                e_stage <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [4:0] d_rs = '0;
    logic [4:0] d_rt = '0;
    logic [1:0] d_tuse_rs = '0;
    logic [1:0] d_tuse_rt = '0;
    logic [4:0] d_a3 = '0;
    logic [4:0] d_tnew = '0;
    logic       d_valid = 1'b0;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    int checks = 0;
    int failures = 0;

    string      name_q[$];
    bit         chk_q[$];
    logic [10:0] exp_q[$];

    hazard_scoreboard #(.TNEW_W(5), .TUSE_W(2)) dut (
        .clk(clk), .reset(reset), .en(en),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_a3(d_a3), .d_tnew(d_tnew), .d_valid(d_valid),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
    );

    always #5 clk = ~clk;

    // Each cycle's inputs are applied just after posedge; the matching expectation
    // is popped at the following negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            string       nm;
            bit          c;
            logic [10:0] ex, got;
            nm  = name_q.pop_front();
            c   = chk_q.pop_front();
            ex  = exp_q.pop_front();
            got = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt};
            if (c) begin
                checks++;
                if (got !== ex) begin
                    failures++;
                    $display("FAIL %s: got stall=%b d_rs=%0d d_rt=%0d e_rs=%0d e_rt=%0d m_rt=%0d, want stall=%b d_rs=%0d d_rt=%0d e_rs=%0d e_rt=%0d m_rt=%0d",
                             nm, got[10], got[9:8], got[7:6], got[5:4], got[3:2], got[1:0],
                             ex[10], ex[9:8], ex[7:6], ex[5:4], ex[3:2], ex[1:0]);
                end
            end
        end
    end

    task automatic cyc(input string nm, input bit chk, input bit rst, input bit e, input bit v,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tr, input logic [1:0] tt,
                       input logic [4:0] a3, input logic [4:0] tn,
                       input logic s, input logic [1:0] fdrs, input logic [1:0] fdrt,
                       input logic [1:0] fers, input logic [1:0] fert, input logic [1:0] fmrt);
        reset = rst; en = e; d_valid = v;
        d_rs = rs; d_rt = rt; d_tuse_rs = tr; d_tuse_rt = tt; d_a3 = a3; d_tnew = tn;
        name_q.push_back(nm);
        chk_q.push_back(chk);
        exp_q.push_back({s, fdrs, fdrt, fers, fert, fmrt});
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle();
        cyc("rst", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst_cycle();
        rst_cycle();
        //   name                chk rst en v   rs  rt  tr tt a3  tn   s fdrs fdrt fers fert fmrt
        cyc("reset_state",       1, 0, 1, 1,  8,  9, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        // load-use: lw $8 then add rs=$8 (Tuse 1)
        cyc("lw8_issue",         1, 0, 1, 1, 29,  0, 1, 0,  8, 2,  0, 0, 0, 0, 0, 0);
        cyc("loaduse_stall",     1, 0, 1, 1,  8,  3, 1, 1, 12, 1,  1, 0, 0, 0, 0, 0);
        cyc("loaduse_release",   1, 0, 1, 1,  8,  3, 1, 1, 12, 1,  0, 0, 0, 0, 0, 0);
        cyc("loaduse_fwd_e",     1, 0, 1, 0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 3, 0, 0);
        rst_cycle();
        // ALU result to branch in D
        cyc("alu9_issue",        1, 0, 1, 1,  1,  2, 1, 1,  9, 1,  0, 0, 0, 0, 0, 0);
        cyc("branch_stall",      1, 0, 1, 1,  9,  0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0);
        cyc("branch_fwd_m",      1, 0, 1, 1,  9,  0, 0, 0,  0, 0,  0, 2, 0, 0, 0, 0);
        rst_cycle();
        // jal then jr $31 with rs == rt
        cyc("jal_issue",         1, 0, 1, 1,  0,  0, 0, 0, 31, 0,  0, 0, 0, 0, 0, 0);
        cyc("jr_fwd_e",          1, 0, 1, 1, 31, 31, 0, 0,  0, 0,  0, 1, 1, 0, 0, 0);
        cyc("e_from_m",          1, 0, 1, 0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 2, 2, 0);
        cyc("d_from_w",          1, 0, 1, 1, 31,  0, 2, 0,  0, 0,  0, 3, 0, 0, 0, 3);
        rst_cycle();
        // store data after load
        cyc("lw10_issue",        1, 0, 1, 1, 29,  0, 1, 0, 10, 2,  0, 0, 0, 0, 0, 0);
        cyc("sw_nostall",        1, 0, 1, 1, 29, 10, 1, 2,  0, 0,  0, 0, 0, 0, 0, 0);
        cyc("sw_e_stale",        1, 0, 1, 0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        cyc("sw_m_from_w",       1, 0, 1, 0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 3);
        rst_cycle();
        // register $0 never matches
        cyc("zero_writer",       1, 0, 1, 1,  0,  0, 0, 0,  0, 2,  0, 0, 0, 0, 0, 0);
        cyc("zero_reader",       1, 0, 1, 1,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        rst_cycle();
        // two writers of $5: nearest one wins
        cyc("add5a",             1, 0, 1, 1,  1,  2, 1, 1,  5, 1,  0, 0, 0, 0, 0, 0);
        cyc("add5b",             1, 0, 1, 1,  3,  4, 1, 1,  5, 1,  0, 0, 0, 0, 0, 0);
        cyc("reader5_d_stale",   1, 0, 1, 1,  5,  6, 1, 1,  7, 1,  0, 0, 0, 0, 0, 0);
        cyc("reader5_e",         1, 0, 1, 1,  5,  7, 1, 1,  0, 0,  0, 2, 0, 2, 0, 0);
        cyc("split_rs_rt",       1, 0, 1, 1,  7,  5, 0, 0,  0, 0,  0, 2, 3, 3, 2, 0);
        rst_cycle();
        // enable freeze during a stall, then reset overriding en=0
        cyc("en_lw",             1, 0, 1, 1, 29,  0, 1, 0,  8, 2,  0, 0, 0, 0, 0, 0);
        cyc("en0_stall",         1, 0, 0, 1,  8,  0, 1, 0, 12, 1,  1, 0, 0, 0, 0, 0);
        cyc("en0_hold",          1, 0, 0, 1,  8,  0, 1, 0, 12, 1,  1, 0, 0, 0, 0, 0);
        cyc("en1_stall",         1, 0, 1, 1,  8,  0, 1, 0, 12, 1,  1, 0, 0, 0, 0, 0);
        cyc("en1_release",       1, 0, 1, 1,  8,  0, 1, 0, 12, 1,  0, 0, 0, 0, 0, 0);
        cyc("rst_mid_pre",       1, 1, 0, 1, 12,  0, 0, 0,  0, 0,  1, 0, 0, 3, 0, 0);
        cyc("after_reset",       1, 0, 1, 1, 12,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
